// File: rtl/spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spike_rate_decoder
// Description : Counts spikes per channel over a programmable window of
//               enabled cycles, snapshots the counts at each window end and
//               streams them out one channel per beat on valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_rate_decoder #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_CH-1:0]  spikes_in,
  input  logic [WIN_W-1:0] win_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_data,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_last,
  output logic             overrun
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt  [N_CH];
  logic [CNT_W-1:0]   r_hold [N_CH];
  logic [WIN_W-1:0]   r_tick;
  logic [WIN_W-1:0]   r_len;
  logic [CH_W-1:0]    r_idx;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_out_data;
  logic [CH_W-1:0]    r_out_ch;
  logic               r_out_last;
  logic               r_overrun;

  logic [CNT_W-1:0]   w_cnt_nxt [N_CH];
  logic               w_win_end;
  logic [CH_W-1:0]    w_idx_inc;

  // Window closes on the enabled cycle where the timer reaches the latched length
  assign w_win_end = ena && (r_tick == r_len);
  assign w_idx_inc = r_idx + CH_W'(1);

  // Saturating next count, including this cycle's spikes (also feeds the snapshot)
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (ena && spikes_in[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Live counters and window timer; length reloads at reset and every window end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick <= '0;
      r_len  <= win_len;
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (w_win_end) begin
      r_tick <= '0;
      r_len  <= win_len;
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (ena) begin
      r_tick <= r_tick + WIN_W'(1);
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Drain FSM with registered stream outputs; runs independently of ena
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_last  <= 1'b0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      // A window ending while a stream is still out is dropped, including
      // the cycle of the final handshake.
      if (w_win_end && (r_state == S_DRAIN)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_win_end) begin
            for (int i = 0; i < N_CH; i++) begin
              r_hold[i] <= w_cnt_nxt[i];
            end
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_out_ch    <= '0;
            r_out_data  <= w_cnt_nxt[0];
            r_out_last  <= (N_CH == 1);
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_idx      <= w_idx_inc;
              r_out_ch   <= w_idx_inc;
              r_out_data <= r_hold[w_idx_inc];
              r_out_last <= (w_idx_inc == CH_W'(N_CH - 1));
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_last  = r_out_last;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire
